alu_cmd_sequencer: RTL and testbench
====================================

Name: alu_cmd_sequencer

Overview:
Upstream issue stage for the mux ALU datapath. It buffers operand/opcode commands from a valid/ready producer in a small FIFO and issues one command at a time to the ALU's combinational operand/select/enable inputs. It captures the ALU's 33-bit result and presents it on a valid/ready response port tagged with the opcode and an invalid-opcode flag. It owns all sequencing so the ALU stays purely combinational.

Parameters:
DEPTH, 4, command FIFO entries (power of 2, >=2)
DATA_W, 32, operand width; result width is DATA_W+1
SEL_W, 4, opcode width

Ports:
clk  input  1  system clock, rising edge
rstn  input  1  asynchronous active-low reset
cmd_valid  input  1  producer has a command
cmd_ready  output  1  FIFO can accept (= !full)
cmd_a  input  DATA_W  operand A
cmd_b  input  DATA_W  operand B
cmd_sel  input  SEL_W  opcode
alu_a  output  DATA_W  to ALU A
alu_b  output  DATA_W  to ALU B
alu_c  output  DATA_W  to ALU C, tied 0
alu_d  output  DATA_W  to ALU D, tied 0
alu_sel  output  SEL_W  to ALU sel_i
alu_enb  output  1  to ALU enb
alu_out  input  DATA_W+1  ALU result
rsp_valid  output  1  response available
rsp_ready  input  1  consumer accepts response
rsp_data  output  DATA_W+1  captured result
rsp_sel  output  SEL_W  opcode of this response
rsp_err  output  1  opcode was invalid (>6)
fifo_count  output  $clog2(DEPTH)+1  entries held

Behaviour:
- Reset (async, rstn=0): FIFO empty, fifo_count=0, cmd_ready=1, state IDLE, alu_a/alu_b/alu_sel=0, alu_enb=0, rsp_valid=0, rsp_data=0, rsp_sel=0, rsp_err=0. In-flight and queued commands are dropped. Asserting reset mid-operation clears everything on the same edge; no partial response is emitted.
- Push: on rising edge when cmd_valid && cmd_ready. cmd_ready = (fifo_count != DEPTH); no push when full. cmd_* are ignored when cmd_valid=0.
- Pointers: wr/rd pointers wrap modulo DEPTH. A simultaneous push and pop leaves fifo_count unchanged.
- FSM states: IDLE, DRIVE, HOLD.
  - IDLE: if FIFO non-empty, pop head into alu_a/alu_b/alu_sel and go to DRIVE. alu_enb=0.
  - DRIVE: alu_enb=1 for exactly this cycle. The operand registers are stable. At the next edge, capture alu_out into rsp_data, alu_sel into rsp_sel, and (alu_sel > 6) into rsp_err. Set rsp_valid=1 and go to HOLD.
  - HOLD: alu_enb=0 and operands hold. rsp_valid stays 1 and rsp_* stay stable until rsp_ready=1.
    - On the edge with rsp_ready=1: if the FIFO is non-empty, pop the next command and go to DRIVE, with rsp_valid=0 in DRIVE. Otherwise go to IDLE with rsp_valid=0.
- Latency: a command pushed at edge N into an empty FIFO with the FSM in IDLE is popped at edge N+1. rsp_valid rises after edge N+2. Peak throughput is one response per 2 cycles.
- Width rules: rsp_data is alu_out verbatim (33 bits). The sequencer performs no arithmetic.
- Invalid opcode: sel 7..15 is still issued. rsp_data = alu_out (ALU drives 0) and rsp_err=1.
- alu_c and alu_d are constant 0 in all states.
- Empty pop never occurs; the FSM only pops when fifo_count > 0.
- Push into a full FIFO while a pop happens the same edge: not accepted, because cmd_ready is based on the current count.

Test Plan:
- Reset then single cmd sel=2, A=FFFFFFFF, B=00000001 -> alu_enb pulses one cycle; rsp_valid rises 2 edges after acceptance; rsp_data=1_00000000, rsp_err=0.
- sel=1, A=5, B=7 -> rsp_data=1_FFFFFFFE. sel=3, A=00010000 -> rsp_data=1_00000000. sel=0, A=F0F0F0F0, B=FF00FF00 -> rsp_data=0_F000F000.
- rsp_ready held 0; push 5 commands back-to-back -> 1 in HOLD + 4 queued; cmd_ready=0 at fifo_count=4; the 6th cmd is not accepted. Release rsp_ready -> responses arrive in push order, every 2 cycles.
- sel=9, A=1234, B=5678 -> rsp_data=0, rsp_err=1, rsp_sel=9. The next valid cmd has rsp_err=0.
- Push and pop on the same edge at fifo_count=2 -> fifo_count stays 2. Pointer wrap after 10 pushes -> order preserved, data intact.
- Assert rstn=0 asynchronously while in DRIVE with 3 queued -> all outputs go to reset values immediately. No response emitted after release; cmd_ready=1 and fifo_count=0.

Source files
------------

// File: rtl/alu_cmd_sequencer.sv
// Issue stage for the combinational mux ALU: buffers commands in a FIFO, issues
// one at a time, and returns the captured ALU result on a valid/ready port.
module alu_cmd_sequencer #(
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned DATA_W = 32,
  parameter int unsigned SEL_W  = 4
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic                     cmd_valid,
  output logic                     cmd_ready,
  input  logic [DATA_W-1:0]        cmd_a,
  input  logic [DATA_W-1:0]        cmd_b,
  input  logic [SEL_W-1:0]         cmd_sel,
  output logic [DATA_W-1:0]        alu_a,
  output logic [DATA_W-1:0]        alu_b,
  output logic [DATA_W-1:0]        alu_c,
  output logic [DATA_W-1:0]        alu_d,
  output logic [SEL_W-1:0]         alu_sel,
  output logic                     alu_enb,
  input  logic [DATA_W:0]          alu_out,
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic [DATA_W:0]          rsp_data,
  output logic [SEL_W-1:0]         rsp_sel,
  output logic                     rsp_err,
  output logic [$clog2(DEPTH):0]   fifo_count
);

  localparam int unsigned PTR_W   = $clog2(DEPTH);
  localparam int unsigned CNT_W   = PTR_W + 1;
  localparam int unsigned MAX_SEL = 6;

  typedef struct packed {
    logic [SEL_W-1:0]  sel;
    logic [DATA_W-1:0] b;
    logic [DATA_W-1:0] a;
  } cmd_t;

  typedef enum logic [1:0] {IDLE, DRIVE, HOLD} state_t;

  state_t            state, state_n;
  cmd_t              mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr, rd_ptr;
  logic              push, pop, capture, enb_n, rsp_valid_n;

  assign cmd_ready = (fifo_count != CNT_W'(DEPTH));
  assign push      = cmd_valid && cmd_ready;
  assign alu_c     = '0;
  assign alu_d     = '0;

  // Sequencing: pop only when entries exist; DRIVE lasts exactly one cycle.
  always_comb begin
    state_n     = state;
    pop         = 1'b0;
    capture     = 1'b0;
    enb_n       = 1'b0;
    rsp_valid_n = rsp_valid;
    case (state)
      IDLE: begin
        if (fifo_count != '0) begin
          pop     = 1'b1;
          enb_n   = 1'b1;
          state_n = DRIVE;
        end
      end
      DRIVE: begin
        capture     = 1'b1;
        rsp_valid_n = 1'b1;
        state_n     = HOLD;
      end
      HOLD: begin
        if (rsp_ready) begin
          rsp_valid_n = 1'b0;
          if (fifo_count != '0) begin
            pop     = 1'b1;
            enb_n   = 1'b1;
            state_n = DRIVE;
          end else begin
            state_n = IDLE;
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state      <= IDLE;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
      alu_a      <= '0;
      alu_b      <= '0;
      alu_sel    <= '0;
      alu_enb    <= 1'b0;
      rsp_valid  <= 1'b0;
      rsp_data   <= '0;
      rsp_sel    <= '0;
      rsp_err    <= 1'b0;
    end else begin
      state     <= state_n;
      alu_enb   <= enb_n;
      rsp_valid <= rsp_valid_n;
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop) begin
        rd_ptr  <= rd_ptr + PTR_W'(1);
        alu_a   <= mem[rd_ptr].a;
        alu_b   <= mem[rd_ptr].b;
        alu_sel <= mem[rd_ptr].sel;
      end
      if (push && !pop)      fifo_count <= fifo_count + CNT_W'(1);
      else if (pop && !push) fifo_count <= fifo_count - CNT_W'(1);
      if (capture) begin
        rsp_data <= alu_out;
        rsp_sel  <= alu_sel;
        rsp_err  <= (alu_sel > SEL_W'(MAX_SEL));
      end
    end
  end

  // Storage needs no reset: entries are only read after being written.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= '{sel: cmd_sel, b: cmd_b, a: cmd_a};
  end

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// Directed bench for alu_cmd_sequencer with a stub ALU and a response scoreboard.
module tb_alu_cmd_sequencer;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned SEL_W  = 4;
  localparam int unsigned DEPTH  = 4;

  logic              clk = 1'b0;
  logic              rstn = 1'b1;
  logic              cmd_valid = 1'b0, cmd_ready;
  logic [DATA_W-1:0] cmd_a = '0, cmd_b = '0;
  logic [SEL_W-1:0]  cmd_sel = '0;
  logic [DATA_W-1:0] alu_a, alu_b, alu_c, alu_d;
  logic [SEL_W-1:0]  alu_sel;
  logic              alu_enb;
  logic [DATA_W:0]   alu_out;
  logic              rsp_valid, rsp_ready = 1'b0;
  logic [DATA_W:0]   rsp_data;
  logic [SEL_W-1:0]  rsp_sel;
  logic              rsp_err;
  logic [2:0]        fifo_count;

  typedef struct packed {
    logic [DATA_W:0]  d;
    logic [SEL_W-1:0] s;
    logic             e;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0, n_err = 0, cyc = 0, last_hs = 0;
  logic rate_on = 1'b0, have_hs = 1'b0, hold_prev = 1'b0, enb_prev = 1'b0;
  logic [DATA_W:0]  prev_data;
  logic [SEL_W-1:0] prev_sel;
  logic             prev_err;

  always #5 clk = ~clk;

  // Stub ALU: and, sub, add, mul, or, xor, not; invalid opcodes drive zero.
  function automatic logic [DATA_W:0] alu_fn(input logic [DATA_W-1:0] a, b, input logic [SEL_W-1:0] s);
    logic [63:0] p;
    p = 64'(a) * 64'(b);
    case (s)
      4'd0: return {1'b0, a & b};
      4'd1: return {1'b0, a} - {1'b0, b};
      4'd2: return {1'b0, a} + {1'b0, b};
      4'd3: return p[DATA_W:0];
      4'd4: return {1'b0, a | b};
      4'd5: return {1'b0, a ^ b};
      4'd6: return {1'b0, ~a};
      default: return '0;
    endcase
  endfunction

  assign alu_out = alu_enb ? alu_fn(alu_a, alu_b, alu_sel) : '0;

  alu_cmd_sequencer #(.DEPTH(DEPTH), .DATA_W(DATA_W), .SEL_W(SEL_W)) dut (
    .clk(clk), .rstn(rstn),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_sel(cmd_sel),
    .alu_a(alu_a), .alu_b(alu_b), .alu_c(alu_c), .alu_d(alu_d),
    .alu_sel(alu_sel), .alu_enb(alu_enb), .alu_out(alu_out),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_data(rsp_data), .rsp_sel(rsp_sel), .rsp_err(rsp_err),
    .fifo_count(fifo_count)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Per-cycle response checking, sampled on the falling edge.
  task automatic monitor();
    exp_t t;
    if (!rstn) begin
      hold_prev = 1'b0;
      enb_prev  = 1'b0;
      have_hs   = 1'b0;
      return;
    end
    chk("alu_c_zero", 64'(alu_c), 0);
    chk("alu_d_zero", 64'(alu_d), 0);
    if (alu_enb) chk("enb_single_cycle", 64'(enb_prev), 0);
    enb_prev = alu_enb;
    if (hold_prev) begin
      chk("hold_valid", 64'(rsp_valid), 1);
      chk("hold_data", 64'(rsp_data), 64'(prev_data));
      chk("hold_sel", 64'(rsp_sel), 64'(prev_sel));
      chk("hold_err", 64'(rsp_err), 64'(prev_err));
    end
    hold_prev = rsp_valid && !rsp_ready;
    prev_data = rsp_data;
    prev_sel  = rsp_sel;
    prev_err  = rsp_err;
    if (!rate_on) have_hs = 1'b0;
    if (rsp_valid && rsp_ready) begin
      if (sb.size() == 0) begin
        chk("unexpected_rsp", 64'(rsp_valid), 0);
      end else begin
        t = sb.pop_front();
        chk("rsp_data", 64'(rsp_data), 64'(t.d));
        chk("rsp_sel", 64'(rsp_sel), 64'(t.s));
        chk("rsp_err", 64'(rsp_err), 64'(t.e));
      end
      if (rate_on && have_hs) chk("rsp_interval", 64'(cyc - last_hs), 2);
      last_hs = cyc;
      have_hs = 1'b1;
    end
  endtask

  task automatic step();
    @(negedge clk);
    monitor();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic push(input logic [DATA_W-1:0] a, b, input logic [SEL_W-1:0] s,
                      input logic [DATA_W:0] ed, input logic ee);
    logic acc;
    exp_t t;
    cmd_valid = 1'b1;
    cmd_a = a;
    cmd_b = b;
    cmd_sel = s;
    acc = 1'b0;
    for (int i = 0; i < 64 && !acc; i++) begin
      acc = cmd_ready;
      step();
    end
    cmd_valid = 1'b0;
    chk("push_accept", 64'(acc), 1);
    if (acc) begin
      t.d = ed;
      t.s = s;
      t.e = ee;
      sb.push_back(t);
    end
  endtask

  task automatic drain();
    for (int i = 0; i < 200 && (sb.size() != 0 || rsp_valid); i++) step();
    chk("drain_empty", 64'(sb.size()), 0);
  endtask

  initial begin
    logic [DATA_W-1:0] ra, rb;
    logic [SEL_W-1:0]  rs;

    // Reset values
    #1 rstn = 1'b0;
    #1;
    chk("rst_cmd_ready", 64'(cmd_ready), 1);
    chk("rst_fifo_count", 64'(fifo_count), 0);
    chk("rst_rsp_valid", 64'(rsp_valid), 0);
    chk("rst_alu_enb", 64'(alu_enb), 0);
    chk("rst_rsp_data", 64'(rsp_data), 0);
    repeat (2) @(posedge clk);
    #2 rstn = 1'b1;
    step();

    // Single command: latency and enable pulse
    push(32'hFFFF_FFFF, 32'h0000_0001, 4'd2, 33'h1_0000_0000, 1'b0);
    chk("t1_count_after_push", 64'(fifo_count), 1);
    chk("t1_enb_n", 64'(alu_enb), 0);
    step();
    chk("t1_enb_n1", 64'(alu_enb), 1);
    chk("t1_valid_n1", 64'(rsp_valid), 0);
    chk("t1_alu_a", 64'(alu_a), 64'h0000_0000_FFFF_FFFF);
    chk("t1_alu_sel", 64'(alu_sel), 2);
    chk("t1_count_popped", 64'(fifo_count), 0);
    step();
    chk("t1_valid_n2", 64'(rsp_valid), 1);
    chk("t1_enb_n2", 64'(alu_enb), 0);
    chk("t1_data_n2", 64'(rsp_data), 64'h1_0000_0000);
    step();
    chk("t1_valid_held", 64'(rsp_valid), 1);
    rsp_ready = 1'b1;
    step();
    chk("t1_valid_dropped", 64'(rsp_valid), 0);
    drain();

    // Distinct opcodes
    push(32'h0000_0005, 32'h0000_0007, 4'd1, 33'h1_FFFF_FFFE, 1'b0);
    push(32'h0001_0000, 32'h0001_0000, 4'd3, 33'h1_0000_0000, 1'b0);
    push(32'hF0F0_F0F0, 32'hFF00_FF00, 4'd0, 33'h0_F000_F000, 1'b0);
    drain();

    // Backpressure: fill, reject 6th, then release at full rate
    rsp_ready = 1'b0;
    push(32'h0000_0011, 32'h0000_0022, 4'd2, 33'h0_0000_0033, 1'b0);
    push(32'h0000_00F0, 32'h0000_000F, 4'd4, 33'h0_0000_00FF, 1'b0);
    push(32'h0000_00FF, 32'h0000_000F, 4'd5, 33'h0_0000_00F0, 1'b0);
    push(32'h0000_0000, 32'h0000_0000, 4'd6, 33'h0_FFFF_FFFF, 1'b0);
    push(32'h0000_0003, 32'h0000_0004, 4'd3, 33'h0_0000_000C, 1'b0);
    chk("bp_count_full", 64'(fifo_count), 4);
    chk("bp_cmd_ready_low", 64'(cmd_ready), 0);
    cmd_valid = 1'b1;
    cmd_a = 32'hDEAD_BEEF;
    cmd_sel = 4'd2;
    repeat (3) step();
    chk("bp_sixth_rejected", 64'(fifo_count), 4);
    cmd_valid = 1'b0;
    rate_on = 1'b1;
    rsp_ready = 1'b1;
    drain();
    rate_on = 1'b0;

    // Invalid opcode, then a valid one
    push(32'h0000_1234, 32'h0000_5678, 4'd9, 33'h0, 1'b1);
    drain();
    push(32'h0000_1234, 32'h0000_5678, 4'd2, 33'h0_0000_68AC, 1'b0);
    drain();

    // Simultaneous push and pop at fifo_count=2
    rsp_ready = 1'b0;
    push(32'h1, 32'h1, 4'd2, 33'h2, 1'b0);
    push(32'h2, 32'h2, 4'd2, 33'h4, 1'b0);
    push(32'h3, 32'h3, 4'd2, 33'h6, 1'b0);
    chk("pp_count_before", 64'(fifo_count), 2);
    rsp_ready = 1'b1;
    push(32'h4, 32'h4, 4'd2, 33'h8, 1'b0);
    chk("pp_count_after", 64'(fifo_count), 2);
    drain();

    // Pointer wrap with pseudo-random traffic
    for (int i = 0; i < 10; i++) begin
      ra = $urandom();
      rb = $urandom();
      rs = SEL_W'($urandom_range(0, 15));
      push(ra, rb, rs, alu_fn(ra, rb, rs), rs > 4'd6);
    end
    drain();

    // Async reset while in DRIVE with 3 queued
    rsp_ready = 1'b0;
    for (int i = 0; i < 5; i++)
      push(32'(i + 1), 32'h10, 4'd2, 33'(i + 17), 1'b0);
    rsp_ready = 1'b1;
    step();
    chk("ar_in_drive", 64'(alu_enb), 1);
    chk("ar_queued", 64'(fifo_count), 3);
    #2 rstn = 1'b0;
    #1;
    chk("ar_fifo_count", 64'(fifo_count), 0);
    chk("ar_cmd_ready", 64'(cmd_ready), 1);
    chk("ar_alu_enb", 64'(alu_enb), 0);
    chk("ar_alu_a", 64'(alu_a), 0);
    chk("ar_alu_b", 64'(alu_b), 0);
    chk("ar_alu_sel", 64'(alu_sel), 0);
    chk("ar_rsp_valid", 64'(rsp_valid), 0);
    chk("ar_rsp_data", 64'(rsp_data), 0);
    chk("ar_rsp_sel", 64'(rsp_sel), 0);
    chk("ar_rsp_err", 64'(rsp_err), 0);
    sb.delete();
    repeat (2) @(posedge clk);
    #2 rstn = 1'b1;
    for (int i = 0; i < 6; i++) begin
      step();
      chk("ar_no_rsp", 64'(rsp_valid), 0);
      chk("ar_no_enb", 64'(alu_enb), 0);
    end
    chk("ar_post_count", 64'(fifo_count), 0);
    chk("ar_post_ready", 64'(cmd_ready), 1);

    // Normal operation resumes after reset
    push(32'h0000_00AA, 32'h0000_0055, 4'd5, 33'h0_0000_00FF, 1'b0);
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
